viterbi_ctrl: RTL

Sequencing controller for the 64-state rate-1/2 hard-decision Viterbi decoder.
- Accepts received symbol pairs through a valid/ready handshake.
- Presents one pair per trellis step to the branch-metric bank.
- Pulses the ACS array and writes each survivor column into a ring-buffer survivor memory.
- Schedules sliding-window and end-of-frame tracebacks, stalling input while a traceback runs.

---
 rtl/viterbi_pkg.sv | 26 ++
 rtl/viterbi_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the 64-state rate-1/2 hard-decision Viterbi decoder.
package viterbi_pkg;

    // Code constraint length and trellis size
    localparam int unsigned K          = 7;
    localparam int unsigned NUM_STATES = 64;

    // Default sliding-window geometry
    localparam int unsigned TB_DEPTH_DEF  = 32;
    localparam int unsigned SM_ADDR_W_DEF = 6;

    // Path metric initial values used by the ACS array when acs_first is set:
    // state 0 starts at zero, all other states start saturated.
    localparam int unsigned        METRIC_W         = 8;
    localparam logic [METRIC_W-1:0] METRIC_INIT_ZERO = '0;
    localparam logic [METRIC_W-1:0] METRIC_INIT_MAX  = '1;

    // Sequencing controller states
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StIssue,
        StWaitTb
    } ctrl_state_e;

endpackage

// File: rtl/viterbi_ctrl.sv
// Viterbi decoder sequencing controller: accepts symbol pairs, steps the ACS
// array, writes survivor columns into a ring buffer and schedules tracebacks.
module viterbi_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned TB_DEPTH  = TB_DEPTH_DEF,
    parameter int unsigned SM_ADDR_W = SM_ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_pair,
    input  logic                 in_last,
    output logic [1:0]           rx_pair,
    output logic                 acs_en,
    output logic                 acs_first,
    output logic                 sm_wr_en,
    output logic [SM_ADDR_W-1:0] sm_wr_addr,
    output logic                 tb_start,
    output logic [SM_ADDR_W-1:0] tb_addr,
    output logic [SM_ADDR_W:0]   tb_trace_len,
    output logic [SM_ADDR_W:0]   tb_dec_len,
    output logic                 tb_final,
    input  logic                 tb_done,
    output logic                 frame_done
);

    localparam int unsigned      LEN_W   = SM_ADDR_W + 1;
    localparam logic [LEN_W-1:0] WIN_LEN = LEN_W'(2 * TB_DEPTH);
    localparam logic [LEN_W-1:0] DEC_LEN = LEN_W'(TB_DEPTH);

    ctrl_state_e          state;
    logic [SM_ADDR_W-1:0] wptr;
    logic [LEN_W-1:0]     pend;
    logic                 last_seen;

    logic                 accept;
    logic [SM_ADDR_W-1:0] wptr_base;
    logic [LEN_W-1:0]     pend_base;
    logic [LEN_W-1:0]     pend_inc;
    logic                 trigger;

    // Ready is a pure state decode so it drops the cycle a traceback is queued
    assign in_ready = ~rst & ((state == StIdle) || (state == StRun));
    assign accept   = in_valid & in_ready;

    // Counter bases: a new frame restarts the ring at 0 with nothing pending
    always_comb begin
        wptr_base = wptr;
        pend_base = pend;
        if (state == StIdle) begin
            wptr_base = '0;
            pend_base = '0;
        end
        pend_inc = pend_base + LEN_W'(1);
        trigger  = in_last | (pend_inc == WIN_LEN);
    end

    // Controller FSM with registered outputs and inline wptr/pend counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            wptr         <= '0;
            pend         <= '0;
            last_seen    <= 1'b0;
            rx_pair      <= '0;
            acs_en       <= 1'b0;
            acs_first    <= 1'b0;
            sm_wr_en     <= 1'b0;
            sm_wr_addr   <= '0;
            tb_start     <= 1'b0;
            tb_addr      <= '0;
            tb_trace_len <= '0;
            tb_dec_len   <= '0;
            tb_final     <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            acs_en     <= 1'b0;
            acs_first  <= 1'b0;
            sm_wr_en   <= 1'b0;
            tb_start   <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                StIdle, StRun: begin
                    if (accept) begin
                        rx_pair    <= in_pair;
                        acs_en     <= 1'b1;
                        sm_wr_en   <= 1'b1;
                        acs_first  <= (state == StIdle);
                        sm_wr_addr <= wptr_base;
                        wptr       <= wptr_base + SM_ADDR_W'(1);
                        pend       <= pend_inc;
                        last_seen  <= in_last;
                        state      <= trigger ? StIssue : StRun;
                    end
                end

                StIssue: begin
                    // sm_wr_addr still holds the step written by the triggering pair
                    tb_start <= 1'b1;
                    tb_addr  <= sm_wr_addr;
                    tb_final <= last_seen;
                    if (last_seen) begin
                        // Frame end decodes everything pending, even a full window
                        tb_trace_len <= pend;
                        tb_dec_len   <= pend;
                        pend         <= '0;
                    end else begin
                        tb_trace_len <= WIN_LEN;
                        tb_dec_len   <= DEC_LEN;
                        pend         <= pend - DEC_LEN;
                    end
                    state <= StWaitTb;
                end

                StWaitTb: begin
                    if (tb_done) begin
                        if (last_seen) begin
                            frame_done <= 1'b1;
                            state      <= StIdle;
                        end else begin
                            state <= StRun;
                        end
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule
